servstolic_qmon: RTL

Observer for the systolic servant array: samples the `nrow*ncol` per-core `q` GPIO lines and counts rising edges per core in saturating counters. On request it snapshots every counter, then streams one record per core (index, count, level) over a valid/ready interface toward a host-side reader. It sits beside the servant array on the same `wb_clk` domain and consumes the array's `q` bus.

---
 rtl/servstolic_qmon_if.sv | 22 ++
 rtl/servstolic_qmon.sv | 112 +++++++++++
 2 files changed

// File: rtl/servstolic_qmon_if.sv
// Record stream from the q-line monitor toward the host-side reader.
interface servstolic_qmon_if #(
    parameter int IDXW = 4,
    parameter int CNTW = 16
);
    logic            o_valid;
    logic            o_ready;
    logic [IDXW-1:0] o_idx;
    logic [CNTW-1:0] o_count;
    logic            o_level;
    logic            o_last;

    modport master (
        output o_valid, o_idx, o_count, o_level, o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid, o_idx, o_count, o_level, o_last,
        output o_ready
    );
endinterface

// File: rtl/servstolic_qmon.sv
// Per-core q edge counters with snapshot-and-stream readout over a valid/ready interface.
// Optional SERVSTOLIC_QMON_FALL_EN: count both edges instead of rising edges only.
module servstolic_qmon #(
    parameter int nrow = 4,
    parameter int ncol = 4,
    parameter int cntw = 16
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    input  logic [nrow*ncol-1:0]   q,
    input  logic                   snap_req,
    output logic                   busy,
    servstolic_qmon_if.master      m
);
    localparam int N    = nrow * ncol;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [cntw-1:0] CNT_MAX  = '1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state_q, state_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic                       snap_take;
    logic [N-1:0]               q_d;
    logic [N-1:0]               edge_det;
    logic [N-1:0][cntw-1:0]     snap_cnt_all;
    logic [N-1:0]               snap_lvl_all;

    // Reset also loads the current level so leaving reset never looks like an edge.
    always_ff @(posedge wb_clk) begin
        q_d <= q;
    end

`ifdef SERVSTOLIC_QMON_FALL_EN
    assign edge_det = q ^ q_d;
`else
    assign edge_det = q & ~q_d;
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_core
            logic [cntw-1:0] cnt_q;
            logic [cntw-1:0] cnt_d;
            logic [cntw-1:0] snap_q;
            logic            lvl_q;

            assign cnt_d = (edge_det[gi] && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

            // The snapshot takes the post-edge value so an edge coinciding with the request is kept.
            always_ff @(posedge wb_clk) begin
                if (!wb_rst_n) begin
                    cnt_q  <= '0;
                    snap_q <= '0;
                    lvl_q  <= 1'b0;
                end else if (snap_take) begin
                    cnt_q  <= '0;
                    snap_q <= cnt_d;
                    lvl_q  <= q[gi];
                end else begin
                    cnt_q  <= cnt_d;
                end
            end

            assign snap_cnt_all[gi] = snap_q;
            assign snap_lvl_all[gi] = lvl_q;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    snap_take = 1'b1;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (m.o_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Record fields are forced to zero outside SEND so the idle bus is quiet.
    assign busy      = (state_q == SEND);
    assign m.o_valid = busy;
    assign m.o_idx   = busy ? idx_q : '0;
    assign m.o_count = busy ? snap_cnt_all[idx_q] : '0;
    assign m.o_level = busy ? snap_lvl_all[idx_q] : 1'b0;
    assign m.o_last  = busy && (idx_q == IDX_LAST);
endmodule
